// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, with a registered borrow.
// Streams each difference bit and presents the assembled result and final borrow at completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             diff_bit_r;
  logic             diff_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             done_r;

  logic             d_s;
  logic             br_next_s;

  // Full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    d_s       = sa_r[0] ^ sb_r[0] ^ br_r;
    br_next_s = (~sa_r[0] & sb_r[0]) | (~(sa_r[0] ^ sb_r[0]) & br_r);
  end

  // Control FSM, operand/result shifting and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      sa_r         <= '0;
      sb_r         <= '0;
      res_r        <= '0;
      br_r         <= 1'b0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      diff_bit_r   <= 1'b0;
      diff_valid_r <= 1'b0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff_bit_r   <= d_s;
          diff_valid_r <= 1'b1;
          br_r         <= br_next_s;
          sa_r         <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r         <= {1'b0, sb_r[WIDTH-1:1]};
          res_r        <= {d_s, res_r[WIDTH-1:1]};
          // Counter stops at its last value so it never wraps mid-operation
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          done_r       <= 1'b1;
          diff_valid_r <= 1'b0;
          diff_r       <= res_r;
          borrow_out_r <= br_r;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          diff_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign diff_bit   = diff_bit_r;
  assign diff_valid = diff_valid_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;
  assign done       = done_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor: results, serial stream, latency,
// handshake while busy and asynchronous reset mid-operation.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         diff_bit;
  logic         diff_valid;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         done;

  int tests_run;
  int tests_failed;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .diff_bit   (diff_bit),
    .diff_valid (diff_valid),
    .diff       (diff),
    .borrow_out (borrow_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from idle; expected values come from the caller
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W-1:0] exp_diff, input logic exp_bor);
    logic [W-1:0] stream;
    stream = '0;
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    a = ta;
    b = tb_;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta;
    b = ~tb_;
    check({tag, " busy0"}, {31'd0, busy}, 32'd1);
    check({tag, " vld0"}, {31'd0, diff_valid}, 32'd0);
    for (int i = 0; i < W; i++) begin
      tick();
      check({tag, " vld"}, {31'd0, diff_valid}, 32'd1);
      check({tag, " early done"}, {31'd0, done}, 32'd0);
      stream[i] = diff_bit;
    end
    check({tag, " busy in done state"}, {31'd0, busy}, 32'd1);
    check({tag, " stream"}, {24'd0, stream}, {24'd0, exp_diff});
    tick();
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " diff"}, {24'd0, diff}, {24'd0, exp_diff});
    check({tag, " borrow"}, {31'd0, borrow_out}, {31'd0, exp_bor});
    check({tag, " vld off"}, {31'd0, diff_valid}, 32'd0);
    check({tag, " bit hold"}, {31'd0, diff_bit}, {31'd0, exp_diff[W-1]});
    check({tag, " busy off"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, " done width"}, {31'd0, done}, 32'd0);
    check({tag, " diff hold"}, {24'd0, diff}, {24'd0, exp_diff});
  endtask

  initial begin
    logic [W:0] ref_v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic exp_done;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst vld", {31'd0, diff_valid}, 32'd0);
    check("rst diff", {24'd0, diff}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1..T3 with hand-computed results
    do_op("T1", 8'h05, 8'h03, 8'h02, 1'b0);
    do_op("T2", 8'h03, 8'h05, 8'hFE, 1'b1);
    do_op("T3a", 8'h00, 8'h00, 8'h00, 1'b0);
    do_op("T3b", 8'hFF, 8'h01, 8'hFE, 1'b0);
    do_op("T3c", 8'h00, 8'hFF, 8'h01, 1'b1);

    // T4: start held high, operands churn while busy; acceptance at E0, E0+10, E0+20
    a = 8'h30;
    b = 8'h10;
    start = 1'b1;
    tick();
    a = 8'hEE;
    b = 8'h11;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_done = (k == 9) || (k == 19) || (k == 29);
      check("T4 done cadence", {31'd0, done}, {31'd0, exp_done});
      if (k == 9) begin
        check("T4 op1 diff", {24'd0, diff}, 32'h20);
        check("T4 op1 borrow", {31'd0, borrow_out}, 32'd0);
      end
      if (k == 19) begin
        check("T4 op2 diff", {24'd0, diff}, 32'h55);
        check("T4 op2 borrow", {31'd0, borrow_out}, 32'd0);
      end
      if (k == 29) begin
        check("T4 op3 diff", {24'd0, diff}, 32'hDE);
        check("T4 op3 borrow", {31'd0, borrow_out}, 32'd1);
      end
      if (k == 9) begin
        a = 8'h77;
        b = 8'h22;
      end else if (k == 19) begin
        a = 8'h12;
        b = 8'h34;
      end else begin
        a = 8'(k * 37);
        b = 8'(k * 91 + 5);
      end
      if (k >= 28) start = 1'b0;
    end
    check("T4 idle after", {31'd0, busy}, 32'd0);

    // T5: asynchronous reset after three serial bits
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("T5 pre vld", {31'd0, diff_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("T5 rst busy", {31'd0, busy}, 32'd0);
    check("T5 rst vld", {31'd0, diff_valid}, 32'd0);
    check("T5 rst bit", {31'd0, diff_bit}, 32'd0);
    check("T5 rst diff", {24'd0, diff}, 32'd0);
    check("T5 rst borrow", {31'd0, borrow_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("T5 no done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("T5 no done after", {31'd0, done}, 32'd0);
    do_op("T5", 8'h10, 8'h01, 8'h0F, 1'b0);

    // T6: random operands against a W+1-bit reference subtraction
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ref_v = {1'b0, ra} - {1'b0, rb};
      do_op("T6", ra, rb, ref_v[W-1:0], ref_v[W]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
